apb_bus_arbiter: RTL

- Shares one APB master port between two bus requesters: M0 (CPU data side, transfer/ready handshake) and M1 (DMA/debug).
- Round-robin arbitration, address decode to NUM_SLV slave selects, and a single SETUP/ACCESS APB sequencer.
- Sits between the multi-cycle CPU's memory-stage bus signals and the APB peripheral fabric.

---
 rtl/apb_bus_arbiter_if.sv | 51 +++++
 rtl/apb_bus_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter_if.sv
// apb_bus_arbiter_if: requester-side handshakes (M0, M1) and the shared APB master port.
// The master modport is the arbiter's view; slave is the view of its surroundings.
interface apb_bus_arbiter_if #(
    parameter int unsigned NUM_SLV = 4
);
    // M0: CPU data side
    logic               m0_transfer;
    logic               m0_write;
    logic [31:0]        m0_addr;
    logic [31:0]        m0_wdata;
    logic [31:0]        m0_rdata;
    logic               m0_ready;
    logic               m0_err;

    // M1: DMA / debug
    logic               m1_transfer;
    logic               m1_write;
    logic [31:0]        m1_addr;
    logic [31:0]        m1_wdata;
    logic [31:0]        m1_rdata;
    logic               m1_ready;
    logic               m1_err;

    // APB fabric
    logic [31:0]        PADDR;
    logic               PWRITE;
    logic [31:0]        PWDATA;
    logic [NUM_SLV-1:0] PSEL;
    logic               PENABLE;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  m0_transfer, m0_write, m0_addr, m0_wdata,
        output m0_rdata, m0_ready, m0_err,
        input  m1_transfer, m1_write, m1_addr, m1_wdata,
        output m1_rdata, m1_ready, m1_err,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output m0_transfer, m0_write, m0_addr, m0_wdata,
        input  m0_rdata, m0_ready, m0_err,
        output m1_transfer, m1_write, m1_addr, m1_wdata,
        input  m1_rdata, m1_ready, m1_err,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: shares one APB master port between two requesters with
// round-robin grant, address decode to NUM_SLV selects and a SETUP/ACCESS sequencer.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS phase at TIMEOUT_CYC wait cycles.
module apb_bus_arbiter #(
    parameter int unsigned NUM_SLV     = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned SEL_LSB     = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               reset,
    apb_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [15:0] REGION = BASE_ADDR[31:16];

    // Reject parameter sets the decode or timeout counter cannot represent
    if (NUM_SLV == 0 || NUM_SLV > 16 || SEL_LSB > 28 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("apb_bus_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

    state_t              state, state_d;
    master_t             last_grant, last_grant_d;
    master_t             gnt, gnt_d;
    logic                miss, miss_d;
    logic [DATA_W-1:0]   paddr, paddr_d;
    logic                pwrite, pwrite_d;
    logic [DATA_W-1:0]   pwdata, pwdata_d;
    logic [NUM_SLV-1:0]  psel, psel_d;
    logic                penable, penable_d;
    logic [DATA_W-1:0]   m0_rdata, m0_rdata_d;
    logic                m0_ready, m0_ready_d;
    logic                m0_err, m0_err_d;
    logic [DATA_W-1:0]   m1_rdata, m1_rdata_d;
    logic                m1_ready, m1_ready_d;
    logic                m1_err, m1_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     to_cnt, to_cnt_d;
`endif

    master_t             req_sel_c;
    logic [DATA_W-1:0]   req_addr_c;
    logic [IDX_W-1:0]    req_idx_c;
    logic                req_hit_c;

    logic                fin_c;
    logic                fin_err_c;
    logic                fin_upd_c;
    logic [DATA_W-1:0]   fin_rdata_c;

    // Pick the requester to serve (alternate on a tie) and decode its address
    always_comb begin
        if (bus.m0_transfer && bus.m1_transfer) begin
            req_sel_c = (last_grant == M0) ? M1 : M0;
        end else if (bus.m1_transfer) begin
            req_sel_c = M1;
        end else begin
            req_sel_c = M0;
        end
        req_addr_c = (req_sel_c == M1) ? bus.m1_addr : bus.m0_addr;
        req_idx_c  = req_addr_c[SEL_LSB +: IDX_W];
        req_hit_c  = (req_addr_c[31:16] == REGION) && (32'(req_idx_c) < NUM_SLV);
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        gnt_d        = gnt;
        miss_d       = miss;
        paddr_d      = paddr;
        pwrite_d     = pwrite;
        pwdata_d     = pwdata;
        psel_d       = psel;
        penable_d    = penable;
        m0_rdata_d   = m0_rdata;
        m0_err_d     = m0_err;
        m0_ready_d   = 1'b0;
        m1_rdata_d   = m1_rdata;
        m1_err_d     = m1_err;
        m1_ready_d   = 1'b0;
        fin_c        = 1'b0;
        fin_err_c    = 1'b0;
        fin_upd_c    = 1'b0;
        fin_rdata_c  = '0;
`ifdef APB_TIMEOUT_EN
        to_cnt_d     = to_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (bus.m0_transfer || bus.m1_transfer) begin
                    gnt_d        = req_sel_c;
                    last_grant_d = req_sel_c;
                    miss_d       = !req_hit_c;
                    paddr_d      = req_addr_c;
                    pwrite_d     = (req_sel_c == M1) ? bus.m1_write : bus.m0_write;
                    pwdata_d     = (req_sel_c == M1) ? bus.m1_wdata : bus.m0_wdata;
                    psel_d       = req_hit_c ? (NUM_SLV'(1) << req_idx_c) : '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                // A decode miss spends this cycle with no PSEL, then completes with an error
                if (miss) begin
                    fin_c       = 1'b1;
                    fin_err_c   = 1'b1;
                    fin_upd_c   = 1'b1;
                    fin_rdata_c = '0;
                end else begin
                    penable_d = 1'b1;
                    state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    fin_c       = 1'b1;
                    fin_err_c   = bus.PSLVERR;
                    fin_upd_c   = !pwrite;
                    fin_rdata_c = bus.PRDATA;
                end
`ifdef APB_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    fin_c       = 1'b1;
                    fin_err_c   = 1'b1;
                    fin_upd_c   = !pwrite;
                    fin_rdata_c = '0;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
`endif
            end
            DONE: begin
                // Requests still held from the finished transfer are not re-sampled here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin_c) begin
            state_d   = DONE;
            psel_d    = '0;
            penable_d = 1'b0;
            if (gnt == M0) begin
                m0_ready_d = 1'b1;
                m0_err_d   = fin_err_c;
                if (fin_upd_c) begin
                    m0_rdata_d = fin_rdata_c;
                end
            end else begin
                m1_ready_d = 1'b1;
                m1_err_d   = fin_err_c;
                if (fin_upd_c) begin
                    m1_rdata_d = fin_rdata_c;
                end
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= M1;
            gnt        <= M0;
            miss       <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= '0;
            penable    <= 1'b0;
            m0_rdata   <= '0;
            m0_ready   <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_ready   <= 1'b0;
            m1_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            gnt        <= gnt_d;
            miss       <= miss_d;
            paddr      <= paddr_d;
            pwrite     <= pwrite_d;
            pwdata     <= pwdata_d;
            psel       <= psel_d;
            penable    <= penable_d;
            m0_rdata   <= m0_rdata_d;
            m0_ready   <= m0_ready_d;
            m0_err     <= m0_err_d;
            m1_rdata   <= m1_rdata_d;
            m1_ready   <= m1_ready_d;
            m1_err     <= m1_err_d;
`ifdef APB_TIMEOUT_EN
            to_cnt     <= to_cnt_d;
`endif
        end
    end

    assign bus.PADDR    = paddr;
    assign bus.PWRITE   = pwrite;
    assign bus.PWDATA   = pwdata;
    assign bus.PSEL     = psel;
    assign bus.PENABLE  = penable;
    assign bus.m0_rdata = m0_rdata;
    assign bus.m0_ready = m0_ready;
    assign bus.m0_err   = m0_err;
    assign bus.m1_rdata = m1_rdata;
    assign bus.m1_ready = m1_ready;
    assign bus.m1_err   = m1_err;

endmodule
